chan_dump: RTL and testbench

- Readout stage directly downstream of channel capture. Once a capture completes, it reads every sample out of the channel RAM queue, oldest first.
- Read order starts at the capture write pointer and wraps circularly.
- Each 8-bit sample is handed to the UART transmitter with a trmt/tx_done handshake.
- Signals cmd_cfg when the whole buffer has been sent, so cmd_cfg can clear capture_done.

---
 rtl/chan_dump.sv | 126 ++++++++++++
 tb/tb_chan_dump.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_dump.sv
// chan_dump: reads every sample of the channel RAM queue out to the UART,
// oldest first, starting at the capture write pointer and wrapping at ENTRIES.
// Optional build macro CHAN_DUMP_SYNC_HDR_EN prepends a 0xA5 sync byte.
module chan_dump #(
   parameter int unsigned ENTRIES = 384,
   parameter int unsigned LOG2    = 9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dump_start,
   input  logic [LOG2-1:0] start_addr,
   output logic [LOG2-1:0] raddr,
   input  logic [7:0]      rdata,
   output logic [7:0]      tx_data,
   output logic            trmt,
   input  logic            tx_done,
   output logic            busy,
   output logic            dump_done
);

`ifdef CHAN_DUMP_SYNC_HDR_EN
   typedef enum logic [2:0] {IDLE, RD, LD, WAIT_TX, HDR} state_t;
`else
   typedef enum logic [1:0] {IDLE, RD, LD, WAIT_TX} state_t;
`endif

   localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);
   localparam logic [LOG2:0]   ENT_EXT  = (LOG2 + 1)'(ENTRIES);

   state_t          state_q, state_d;
   logic [LOG2-1:0] raddr_q, raddr_d;
   logic [LOG2-1:0] smpl_cnt_q, smpl_cnt_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            trmt_q, trmt_d;
   logic            busy_q, busy_d;
   logic            dump_done_q, dump_done_d;
   logic            start_ok;
   logic            tx_ack;

   // Start pointers beyond the RAM depth fall back to address 0.
   assign start_ok = {1'b0, start_addr} < ENT_EXT;
   // A tx_done coinciding with our own trmt pulse cannot belong to this byte.
   assign tx_ack   = tx_done && !trmt_q;

   // Next-state and next-output computation for the readout sequencer.
   always_comb begin
      state_d     = state_q;
      raddr_d     = raddr_q;
      smpl_cnt_d  = smpl_cnt_q;
      tx_data_d   = tx_data_q;
      trmt_d      = 1'b0;
      busy_d      = busy_q;
      dump_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (dump_start) begin
               raddr_d    = start_ok ? start_addr : '0;
               smpl_cnt_d = '0;
               busy_d     = 1'b1;
`ifdef CHAN_DUMP_SYNC_HDR_EN
               tx_data_d  = 8'hA5;
               trmt_d     = 1'b1;
               state_d    = HDR;
`else
               state_d    = RD;
`endif
            end
         end
`ifdef CHAN_DUMP_SYNC_HDR_EN
         HDR: begin
            if (tx_ack) state_d = RD;
         end
`endif
         RD: begin
            state_d = LD;
         end
         LD: begin
            tx_data_d = rdata;
            trmt_d    = 1'b1;
            state_d   = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_ack) begin
               if (smpl_cnt_q == LAST_IDX) begin
                  dump_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = IDLE;
               end else begin
                  smpl_cnt_d = smpl_cnt_q + 1'b1;
                  raddr_d    = (raddr_q == LAST_IDX) ? '0 : raddr_q + 1'b1;
                  state_d    = RD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; asynchronous reset aborts any dump in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         raddr_q     <= '0;
         smpl_cnt_q  <= '0;
         tx_data_q   <= '0;
         trmt_q      <= 1'b0;
         busy_q      <= 1'b0;
         dump_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         smpl_cnt_q  <= smpl_cnt_d;
         tx_data_q   <= tx_data_d;
         trmt_q      <= trmt_d;
         busy_q      <= busy_d;
         dump_done_q <= dump_done_d;
      end
   end

   assign raddr     = raddr_q;
   assign tx_data   = tx_data_q;
   assign trmt      = trmt_q;
   assign busy      = busy_q;
   assign dump_done = dump_done_q;

endmodule

// File: tb/tb_chan_dump.sv
// tb_chan_dump: directed bench for chan_dump with a synchronous RAM model
// (RAM[i] = i[7:0]) and a UART model that answers each trmt with tx_done.
module tb_chan_dump;

   localparam int unsigned ENTRIES = 384;
   localparam int unsigned LOG2    = 9;
`ifdef CHAN_DUMP_SYNC_HDR_EN
   localparam int HDR_N     = 1;
   localparam int FIRST_LAT = 1;
`else
   localparam int HDR_N     = 0;
   localparam int FIRST_LAT = 3;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            dump_start;
   logic [LOG2-1:0] start_addr;
   logic [LOG2-1:0] raddr;
   logic [7:0]      rdata;
   logic [7:0]      tx_data;
   logic            trmt;
   logic            tx_done;
   logic            busy;
   logic            dump_done;

   logic [7:0] mem [2**LOG2];

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;
   int tx_lat  = 20;
   int start_cyc;

   int trmt_addr [$];
   int trmt_data [$];
   int trmt_cyc  [$];
   int txd_cyc   [$];
   int done_cnt;
   int done_cyc;
   int busy_at_done;

   chan_dump #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
      .clk        (clk),
      .rst        (rst),
      .dump_start (dump_start),
      .start_addr (start_addr),
      .raddr      (raddr),
      .rdata      (rdata),
      .tx_data    (tx_data),
      .trmt       (trmt),
      .tx_done    (tx_done),
      .busy       (busy),
      .dump_done  (dump_done)
   );

   always #5 clk = ~clk;

   // Edge counter used to timestamp observed events.
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM: data valid one cycle after the address.
   always @(posedge clk) rdata <= mem[raddr];

   task automatic check_val(input string tag, input int obs, input int exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor: records each transmitted byte and each dump_done pulse.
   initial forever begin
      @(posedge clk); #1;
      if (trmt === 1'b1) begin
         trmt_addr.push_back(int'(raddr));
         trmt_data.push_back(int'(tx_data));
         trmt_cyc.push_back(cyc);
      end
      if (dump_done === 1'b1) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = int'(busy);
      end
   end

   // UART model: tx_done for one cycle, tx_lat cycles after each trmt.
   initial begin
      tx_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (trmt === 1'b1) begin
            repeat (tx_lat) @(posedge clk);
            #1;
            tx_done = 1'b1;
            txd_cyc.push_back(cyc);
            @(posedge clk); #1;
            tx_done = 1'b0;
         end
      end
   end

   task automatic start_dump(input int sa);
      @(posedge clk); #2;
      trmt_addr.delete(); trmt_data.delete(); trmt_cyc.delete(); txd_cyc.delete();
      done_cnt = 0; done_cyc = 0; busy_at_done = -1;
      start_addr = LOG2'(sa);
      dump_start = 1'b1;
      start_cyc  = cyc;
      @(posedge clk); #2;
      dump_start = 1'b0;
   endtask

   task automatic wait_done(input int repulse_at);
      bit pulsed = 0;
      for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
         @(posedge clk); #2;
         if (repulse_at > 0 && !pulsed && trmt_cyc.size() == repulse_at) begin
            start_addr = LOG2'(5);
            dump_start = 1'b1;
            @(posedge clk); #2;
            dump_start = 1'b0;
            pulsed = 1;
         end
      end
      check_val("done_seen", int'(done_cnt > 0), 1);
      repeat (30) @(posedge clk);
      #2;
      check_val("done_single", done_cnt, 1);
      check_val("busy_idle", int'(busy), 0);
   endtask

   task automatic check_dump(input int sa);
      int first, n, m, bad_addr, bad_data, bad_lat, distinct, j, ea;
      bit seen [2**LOG2];
      first = (sa < int'(ENTRIES)) ? sa : 0;
      n = int'(ENTRIES) + HDR_N;
      m = trmt_addr.size();
      check_val("byte_count", m, n);
      check_val("txdone_count", txd_cyc.size(), n);
      bad_addr = 0; bad_data = 0; bad_lat = 0; distinct = 0;
      foreach (seen[i]) seen[i] = 0;
      for (int k = 0; k < m; k++) begin
         if (k < HDR_N) begin
            if (trmt_data[k] != 8'hA5) bad_data++;
         end else begin
            j  = k - HDR_N;
            ea = (first + j) % int'(ENTRIES);
            if (trmt_addr[k] != ea) bad_addr++;
            if (trmt_data[k] != (ea % 256)) bad_data++;
            if (trmt_addr[k] >= 0 && trmt_addr[k] < 2**LOG2 && !seen[trmt_addr[k]]) begin
               seen[trmt_addr[k]] = 1;
               distinct++;
            end
         end
      end
      check_val("addr_seq_errs", bad_addr, 0);
      check_val("data_seq_errs", bad_data, 0);
      check_val("distinct_addrs", distinct, int'(ENTRIES));
      for (int k = 0; k + 1 < m && k < txd_cyc.size(); k++)
         if (trmt_cyc[k+1] - txd_cyc[k] != 3) bad_lat++;
      check_val("txdone_to_trmt_errs", bad_lat, 0);
      if (m > 0) check_val("start_to_trmt", trmt_cyc[0] - start_cyc, FIRST_LAT);
      if (txd_cyc.size() > 0)
         check_val("last_txdone_to_done", done_cyc - txd_cyc[txd_cyc.size()-1], 1);
      check_val("busy_at_done", busy_at_done, 0);
   endtask

   initial begin
      int n_before;
      for (int i = 0; i < 2**LOG2; i++) mem[i] = i[7:0];
      rst = 1'b1; dump_start = 1'b0; start_addr = '0;
      repeat (3) @(posedge clk);
      #2;
      check_val("rst_raddr", int'(raddr), 0);
      check_val("rst_tx_data", int'(tx_data), 0);
      check_val("rst_trmt", int'(trmt), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_dump_done", int'(dump_done), 0);
      rst = 1'b0;

      // Full dump from address 0, slow UART.
      tx_lat = 20;
      start_dump(0);
      #1 check_val("busy_after_start", int'(busy), 1);
      wait_done(0);
      check_dump(0);
      if (trmt_data.size() == ENTRIES + HDR_N) begin
         check_val("byte256_data", trmt_data[256 + HDR_N], 8'h00);
         check_val("last_data", trmt_data[383 + HDR_N], 8'h7F);
      end

      tx_lat = 4;
      // Start mid-buffer: the 285th sample wraps to RAM[0].
      start_dump(100);
      wait_done(0);
      check_dump(100);
      if (trmt_addr.size() == ENTRIES + HDR_N) begin
         check_val("byte285_addr", trmt_addr[284 + HDR_N], 0);
         check_val("byte285_data", trmt_data[284 + HDR_N], 0);
      end

      // Start at last entry: second read wraps to 0.
      start_dump(383);
      wait_done(0);
      check_dump(383);
      if (trmt_addr.size() >= 2 + HDR_N) begin
         check_val("sa383_first", trmt_addr[HDR_N], 383);
         check_val("sa383_second", trmt_addr[1 + HDR_N], 0);
      end

      // Out-of-range start is clamped to 0.
      start_dump(400);
      wait_done(0);
      check_dump(400);
      if (trmt_addr.size() >= 1 + HDR_N) check_val("sa400_first", trmt_addr[HDR_N], 0);

      // dump_start re-pulsed during byte 10 must be ignored.
      start_dump(0);
      wait_done(10);
      check_dump(0);

      // Reset in WAIT_TX at byte 50.
      tx_lat = 20;
      start_dump(0);
      for (int c = 0; c < 5000 && trmt_cyc.size() < 50; c++) @(posedge clk);
      check_val("reached_byte50", trmt_cyc.size(), 50);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("midrst_raddr", int'(raddr), 0);
      check_val("midrst_tx_data", int'(tx_data), 0);
      check_val("midrst_trmt", int'(trmt), 0);
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_dump_done", int'(dump_done), 0);
      @(posedge clk); #2 rst = 1'b0;
      n_before = trmt_cyc.size();
      repeat (40) @(posedge clk);
      #2;
      check_val("postrst_no_trmt", trmt_cyc.size(), n_before);
      check_val("postrst_no_done", done_cnt, 0);
      check_val("postrst_busy", int'(busy), 0);

      // Fresh dump after reset.
      tx_lat = 4;
      start_dump(0);
      wait_done(0);
      check_dump(0);
      if (trmt_addr.size() >= 1 + HDR_N) check_val("restart_first", trmt_addr[HDR_N], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
